// File: rtl/sum_checker.sv
// sum_checker: recovers b from the adder's sum, compares it against the delayed b and keeps pass/error statistics.
module sum_checker #(
  parameter int WIDTH       = 8,
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  output logic             chk_valid,
  output logic [WIDTH-1:0] b_rec,
  output logic             match,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_sum,
  output logic             halted,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
  state_t state_q, state_d;
  logic [LATENCY-1:0] dv_q, dv_d;
  logic [LATENCY-1:0][WIDTH-1:0] da_q, da_d, db_q, db_d;
  logic [3:0] arm_q, arm_d;
  logic chk_valid_q, chk_valid_d, match_q, match_d, err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0] b_rec_q, b_rec_d, fa_q, fa_d, fb_q, fb_d, fs_q, fs_d, diff;
  logic [CNT_W-1:0] pass_q, pass_d, err_q, err_d;
  logic check, same, bad, cap;
  always_comb begin
    dv_d = dv_q;
    da_d = da_q;
    db_d = db_q;
    dv_d[0] = in_valid;
    da_d[0] = a;
    db_d[0] = b;
    for (int i = 1; i < LATENCY; i++) begin
      dv_d[i] = dv_q[i-1];
      da_d[i] = da_q[i-1];
      db_d[i] = db_q[i-1];
    end
    diff = sum - da_q[LATENCY-1];
    same = diff == db_q[LATENCY-1];
    // clear suppresses the compare entirely so nothing from that edge is reported
    check = !clear && state_q == RUN && dv_q[LATENCY-1];
    bad = check && !same;
    cap = bad && !err_sticky_q;
    chk_valid_d = check;
    b_rec_d = check ? diff : b_rec_q;
    match_d = check ? same : match_q;
    pass_d = (check && same && pass_q != '1) ? pass_q + CNT_W'(1) : pass_q;
    err_d = (bad && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    err_sticky_d = err_sticky_q | bad;
    fa_d = cap ? da_q[LATENCY-1] : fa_q;
    fb_d = cap ? db_q[LATENCY-1] : fb_q;
    fs_d = cap ? sum : fs_q;
    state_d = state_q;
    arm_d = arm_q;
    case (state_q)
      IDLE: begin
        state_d = enable ? ARM : IDLE;
        arm_d = '0;
      end
      ARM: begin
        state_d = !enable ? IDLE : (arm_q == 4'(LATENCY - 1)) ? RUN : ARM;
        arm_d = arm_q + 4'd1;
      end
      RUN: state_d = !enable ? IDLE : (bad && HALT_ON_ERR != 0) ? HALT : RUN;
      default: state_d = HALT;
    endcase
    if (clear) begin
      state_d = ARM;
      arm_d = '0;
      pass_d = '0;
      err_d = '0;
      err_sticky_d = 1'b0;
      fa_d = '0;
      fb_d = '0;
      fs_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      arm_q <= '0;
      dv_q <= '0;
      da_q <= '0;
      db_q <= '0;
      chk_valid_q <= 1'b0;
      b_rec_q <= '0;
      match_q <= 1'b0;
      err_sticky_q <= 1'b0;
      pass_q <= '0;
      err_q <= '0;
      fa_q <= '0;
      fb_q <= '0;
      fs_q <= '0;
    end else begin
      state_q <= state_d;
      arm_q <= arm_d;
      dv_q <= dv_d;
      da_q <= da_d;
      db_q <= db_d;
      chk_valid_q <= chk_valid_d;
      b_rec_q <= b_rec_d;
      match_q <= match_d;
      err_sticky_q <= err_sticky_d;
      pass_q <= pass_d;
      err_q <= err_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      fs_q <= fs_d;
    end
  end
  assign chk_valid = chk_valid_q;
  assign b_rec = b_rec_q;
  assign match = match_q;
  assign err_sticky = err_sticky_q;
  assign pass_count = pass_q;
  assign err_count = err_q;
  assign first_err_a = fa_q;
  assign first_err_b = fb_q;
  assign first_err_sum = fs_q;
  assign halted = state_q == HALT;
  assign state = state_q;
endmodule
